// File: rtl/true_dpr_be.sv
// True dual-port RAM with byte-lane write enables, per-port read-during-write mode,
// same-address collision flag and a post-reset clear sequencer. Optional macro TRUE_DPR_OUTREG_EN.
module true_dpr_be #(
  parameter int ADDR_SIZE  = 8,
  parameter int DATA_SIZE  = 8,
  parameter int BYTE_SIZE  = 8,
  parameter int RAM_SIZE   = 1 << ADDR_SIZE,
  parameter int RDW_MODE_A = 0,
  parameter int RDW_MODE_B = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en_a,
  input  logic [DATA_SIZE/BYTE_SIZE-1:0] we_a,
  input  logic [ADDR_SIZE-1:0]           addr_a,
  input  logic [DATA_SIZE-1:0]           din_a,
  output logic [DATA_SIZE-1:0]           dout_a,
  input  logic                           en_b,
  input  logic [DATA_SIZE/BYTE_SIZE-1:0] we_b,
  input  logic [ADDR_SIZE-1:0]           addr_b,
  input  logic [DATA_SIZE-1:0]           din_b,
  output logic [DATA_SIZE-1:0]           dout_b,
  output logic                           init_busy,
  output logic                           collision
);

  // state | meaning
  // CLEAR | zeroing mem[ptr] each cycle, ports ignored
  // READY | normal dual-port operation
  localparam int NB = DATA_SIZE / BYTE_SIZE;
  localparam int IW = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1;
  localparam logic [ADDR_SIZE-1:0] LAST = ADDR_SIZE'(RAM_SIZE - 1);
  localparam logic [ADDR_SIZE:0]   LIMIT = (ADDR_SIZE + 1)'(RAM_SIZE);

  typedef enum logic {CLEAR, READY} state_t;

  state_t               state;
  logic [ADDR_SIZE-1:0] ptr;
  logic [DATA_SIZE-1:0] mem [RAM_SIZE];

  logic                 acc_a, acc_b, ok_a, ok_b, ld_a, ld_b, coll_nxt;
  logic [IW-1:0]        idx_a, idx_b;
  logic [NB-1:0]        wr_a, wr_b;
  logic [DATA_SIZE-1:0] old_a, old_b, q_a, q_b;
  logic                 q_coll;

  // Next read word; mode 0 overlays this port's own written lanes onto the
  // pre-write word, every other case returns the pre-write word.
  function automatic logic [DATA_SIZE-1:0] rd_word(input logic [DATA_SIZE-1:0] old,
                                                   input logic [DATA_SIZE-1:0] din,
                                                   input logic [NB-1:0]        we,
                                                   input logic                 ok,
                                                   input int                   mode);
    logic [DATA_SIZE-1:0] w;
    w = old;
    if (!ok) begin
      w = '0;
    end else if (mode == 0) begin
      for (int i = 0; i < NB; i++) begin
        if (we[i]) w[i*BYTE_SIZE +: BYTE_SIZE] = din[i*BYTE_SIZE +: BYTE_SIZE];
      end
    end
    return w;
  endfunction

  always_comb begin
    acc_a    = (state == READY) && en_a;
    acc_b    = (state == READY) && en_b;
    ok_a     = {1'b0, addr_a} < LIMIT;
    ok_b     = {1'b0, addr_b} < LIMIT;
    idx_a    = addr_a[IW-1:0];
    idx_b    = addr_b[IW-1:0];
    old_a    = ok_a ? mem[idx_a] : '0;
    old_b    = ok_b ? mem[idx_b] : '0;
    wr_a     = (acc_a && ok_a) ? we_a : '0;
    wr_b     = (acc_b && ok_b) ? we_b : '0;
    // no-change mode keeps dout on a real write; out-of-range still forces 0
    ld_a     = acc_a && !(ok_a && (|we_a) && (RDW_MODE_A == 2));
    ld_b     = acc_b && !(ok_b && (|we_b) && (RDW_MODE_B == 2));
    coll_nxt = acc_a && acc_b && ok_a && ok_b && (addr_a == addr_b) && ((|we_a) || (|we_b));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= CLEAR;
      ptr    <= '0;
      q_a    <= '0;
      q_b    <= '0;
      q_coll <= 1'b0;
    end else begin
      q_coll <= coll_nxt;
      if (ld_a) q_a <= rd_word(old_a, din_a, we_a, ok_a, RDW_MODE_A);
      if (ld_b) q_b <= rd_word(old_b, din_b, we_b, ok_b, RDW_MODE_B);
      if (state == CLEAR) begin
        ptr <= ptr + ADDR_SIZE'(1);
        if (ptr == LAST) state <= READY;
      end
    end
  end

  // Port B is written first so port A's lane wins on a shared-lane collision.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[ptr[IW-1:0]] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (wr_b[i]) mem[idx_b][i*BYTE_SIZE +: BYTE_SIZE] <= din_b[i*BYTE_SIZE +: BYTE_SIZE];
        if (wr_a[i]) mem[idx_a][i*BYTE_SIZE +: BYTE_SIZE] <= din_a[i*BYTE_SIZE +: BYTE_SIZE];
      end
    end
  end

  assign init_busy = (state == CLEAR);

`ifdef TRUE_DPR_OUTREG_EN
  logic                 v_a, v_b, o_coll;
  logic [DATA_SIZE-1:0] o_a, o_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_a    <= 1'b0;
      v_b    <= 1'b0;
      o_a    <= '0;
      o_b    <= '0;
      o_coll <= 1'b0;
    end else begin
      v_a    <= acc_a;
      v_b    <= acc_b;
      o_coll <= q_coll;
      if (v_a) o_a <= q_a;
      if (v_b) o_b <= q_b;
    end
  end

  assign dout_a    = o_a;
  assign dout_b    = o_b;
  assign collision = o_coll;
`else
  assign dout_a    = q_a;
  assign dout_b    = q_b;
  assign collision = q_coll;
`endif

endmodule

// File: tb/tb_true_dpr_be.sv
// Directed bench for true_dpr_be: clear sequencer, byte lanes, RDW modes, collisions, range limits.
module tb_true_dpr_be;

  localparam int AW = 6;
  localparam int DW = 16;
  localparam int RS = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic          en_a, en_b;
  logic [1:0]    we_a, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] din_a, din_b;
  logic [DW-1:0] dout_a, dout_b, dout_a2, dout_b2;
  logic          init_busy, collision, init_busy2, collision2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Port A write-first, port B read-first
  true_dpr_be #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .BYTE_SIZE(8), .RAM_SIZE(RS),
                .RDW_MODE_A(0), .RDW_MODE_B(1)) dut (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b),
    .init_busy(init_busy), .collision(collision));

  // Same stimulus, no-change mode on both ports
  true_dpr_be #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .BYTE_SIZE(8), .RAM_SIZE(RS),
                .RDW_MODE_A(2), .RDW_MODE_B(2)) dut2 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a2),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b2),
    .init_busy(init_busy2), .collision(collision2));

  typedef struct {
    logic          en_a;
    logic [1:0]    we_a;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] din_a;
    logic          en_b;
    logic [1:0]    we_b;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] din_b;
    logic [DW-1:0] exp_a;
    logic [DW-1:0] exp_b;
    logic          exp_c;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ea, input logic [1:0] wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                       input logic eb, input logic [1:0] wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
    en_a = ea; we_a = wa; addr_a = aa; din_a = da;
    en_b = eb; we_b = wb; addr_b = ab; din_b = db;
  endtask

  initial begin
    int cnt;
    logic dirty;

    tbl[0]  = '{1'b1, 2'b11, 6'd5,  16'hA1B2, 1'b0, 2'b00, 6'd0,  16'h0000, 16'hA1B2, 16'h0000, 1'b0};
    tbl[1]  = '{1'b1, 2'b10, 6'd5,  16'h7700, 1'b0, 2'b00, 6'd0,  16'h0000, 16'h77B2, 16'h0000, 1'b0};
    tbl[2]  = '{1'b1, 2'b00, 6'd5,  16'h0000, 1'b1, 2'b00, 6'd5,  16'h0000, 16'h77B2, 16'h77B2, 1'b0};
    tbl[3]  = '{1'b0, 2'b00, 6'd0,  16'h0000, 1'b1, 2'b11, 6'd3,  16'h0011, 16'h77B2, 16'h0000, 1'b0};
    tbl[4]  = '{1'b1, 2'b11, 6'd3,  16'h0022, 1'b1, 2'b00, 6'd7,  16'h0000, 16'h0022, 16'h0000, 1'b0};
    tbl[5]  = '{1'b0, 2'b00, 6'd0,  16'h0000, 1'b1, 2'b11, 6'd3,  16'h0033, 16'h0022, 16'h0022, 1'b0};
    tbl[6]  = '{1'b1, 2'b11, 6'h10, 16'h0016, 1'b1, 2'b11, 6'h10, 16'h0013, 16'h0016, 16'h0000, 1'b1};
    tbl[7]  = '{1'b1, 2'b00, 6'h10, 16'h0000, 1'b1, 2'b00, 6'h10, 16'h0000, 16'h0016, 16'h0016, 1'b0};
    tbl[8]  = '{1'b0, 2'b00, 6'd0,  16'h0000, 1'b1, 2'b11, 6'h11, 16'h0055, 16'h0016, 16'h0000, 1'b0};
    tbl[9]  = '{1'b1, 2'b11, 6'h11, 16'h00A1, 1'b1, 2'b00, 6'h11, 16'h0000, 16'h00A1, 16'h0055, 1'b1};
    tbl[10] = '{1'b0, 2'b00, 6'd0,  16'h0000, 1'b1, 2'b00, 6'h11, 16'h0000, 16'h00A1, 16'h00A1, 1'b0};
    tbl[11] = '{1'b1, 2'b01, 6'h12, 16'h00CC, 1'b1, 2'b10, 6'h12, 16'hDD00, 16'h00CC, 16'h0000, 1'b1};
    tbl[12] = '{1'b1, 2'b00, 6'h12, 16'h0000, 1'b1, 2'b00, 6'h12, 16'h0000, 16'hDDCC, 16'hDDCC, 1'b0};
    tbl[13] = '{1'b1, 2'b11, 6'd40, 16'hFFFF, 1'b1, 2'b11, 6'd40, 16'h1234, 16'h0000, 16'h0000, 1'b0};
    tbl[14] = '{1'b1, 2'b11, 6'd39, 16'hBEEF, 1'b1, 2'b00, 6'd0,  16'h0000, 16'hBEEF, 16'h0000, 1'b0};
    tbl[15] = '{1'b1, 2'b00, 6'd39, 16'h0000, 1'b1, 2'b00, 6'd39, 16'h0000, 16'hBEEF, 16'hBEEF, 1'b0};
    tbl[16] = '{1'b0, 2'b11, 6'd39, 16'h0000, 1'b0, 2'b00, 6'd39, 16'h0000, 16'hBEEF, 16'hBEEF, 1'b0};
    tbl[17] = '{1'b1, 2'b00, 6'd39, 16'h0000, 1'b1, 2'b00, 6'd40, 16'h0000, 16'hBEEF, 16'h0000, 1'b0};
    tbl[18] = '{1'b1, 2'b11, 6'd5,  16'h1111, 1'b0, 2'b00, 6'd5,  16'h0000, 16'h1111, 16'h0000, 1'b0};
    tbl[19] = '{1'b1, 2'b00, 6'd3,  16'h0000, 1'b1, 2'b00, 6'd5,  16'h0000, 16'h0033, 16'h1111, 1'b0};

    rst = 1'b1;
    drive(1'b0, 2'b00, '0, '0, 1'b0, 2'b00, '0, '0);
    repeat (2) @(negedge clk);
    chk("reset dout_a", 32'(dout_a), 32'h0);
    chk("reset dout_b", 32'(dout_b), 32'h0);
    chk("reset collision", 32'(collision), 32'h0);
    chk("reset init_busy", 32'(init_busy), 32'h1);

    // Start a clear with writes pending, then cut it short after 7 cycles
    rst = 1'b0;
    drive(1'b1, 2'b11, 6'd3, 16'hFFFF, 1'b1, 2'b11, 6'd3, 16'hEEEE);
    repeat (7) @(negedge clk);
    chk("mid-clear busy", 32'(init_busy), 32'h1);
    chk("mid-clear collision", 32'(collision), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("re-reset dout_a", 32'(dout_a), 32'h0);
    chk("re-reset busy", 32'(init_busy), 32'h1);
    rst = 1'b0;

    cnt = 0;
    dirty = 1'b0;
    while (init_busy === 1'b1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
      if (dout_a !== '0 || dout_b !== '0 || collision !== 1'b0) dirty = 1'b1;
    end
    chk("clear cycle count", 32'(cnt), 32'(RS));
    chk("outputs quiet during clear", 32'(dirty), 32'h0);
    chk("dut2 busy after clear", 32'(init_busy2), 32'h0);

    for (int i = 0; i < RS; i++) begin
      drive(1'b1, 2'b00, AW'(i), '0, 1'b1, 2'b00, AW'(RS - 1 - i), '0);
      @(negedge clk);
      chk($sformatf("cleared a[%0d]", i), 32'(dout_a), 32'h0);
      chk($sformatf("cleared b[%0d]", RS - 1 - i), 32'(dout_b), 32'h0);
    end

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].en_a, tbl[i].we_a, tbl[i].addr_a, tbl[i].din_a,
            tbl[i].en_b, tbl[i].we_b, tbl[i].addr_b, tbl[i].din_b);
      @(negedge clk);
      chk($sformatf("vec%0d dout_a", i), 32'(dout_a), 32'(tbl[i].exp_a));
      chk($sformatf("vec%0d dout_b", i), 32'(dout_b), 32'(tbl[i].exp_b));
      chk($sformatf("vec%0d collision", i), 32'(collision), 32'(tbl[i].exp_c));
    end

    // No-change mode against write-first on the same write
    drive(1'b1, 2'b11, 6'd3, 16'h0011, 1'b0, 2'b00, '0, '0);
    @(negedge clk);
    drive(1'b1, 2'b00, 6'd3, 16'h0000, 1'b0, 2'b00, '0, '0);
    @(negedge clk);
    chk("rdw setup dut dout_a", 32'(dout_a), 32'h0011);
    chk("rdw setup dut2 dout_a", 32'(dout_a2), 32'h0011);
    drive(1'b1, 2'b11, 6'd3, 16'h0022, 1'b0, 2'b00, '0, '0);
    @(negedge clk);
    chk("rdw mode0 dout_a", 32'(dout_a), 32'h0022);
    chk("rdw mode2 dout_a", 32'(dout_a2), 32'h0011);
    drive(1'b1, 2'b00, 6'd3, 16'h0000, 1'b0, 2'b00, '0, '0);
    @(negedge clk);
    chk("rdw mode2 plain read", 32'(dout_a2), 32'h0022);

    // Async reset during operation clears outputs immediately
    rst = 1'b1;
    #1;
    chk("async reset dout_a", 32'(dout_a), 32'h0);
    chk("async reset busy", 32'(init_busy), 32'h1);
    rst = 1'b0;
    drive(1'b0, 2'b00, '0, '0, 1'b0, 2'b00, '0, '0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/true_dpr_be.md
# true_dpr_be

Parametrised true dual-port RAM, successor to the team's basic true dual-port RAM. It adds per-byte write enables, a per-port read-during-write mode, deterministic same-address collision resolution with a collision flag, and a post-reset clear sequencer that zeroes the whole array. Both ports share one clock. The block sits wherever two independent masters need shared random-access storage, such as DMA/CPU mailboxes or packet buffers.

## Interface
Parameters:
- ADDR_SIZE, 8, address width in bits
- DATA_SIZE, 8, word width in bits; must be a multiple of BYTE_SIZE
- BYTE_SIZE, 8, bits per byte lane; NB = DATA_SIZE/BYTE_SIZE lanes
- RAM_SIZE, 1 << ADDR_SIZE, number of words; 1 ≤ RAM_SIZE ≤ 2^ADDR_SIZE
- RDW_MODE_A, 0, port A read-during-write: 0 write-first, 1 read-first, 2 no-change
- RDW_MODE_B, 0, port B read-during-write, same encoding

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en_a / en_b  in  1  port enable
- we_a / we_b  in  NB  per-byte-lane write enable; lane i covers din bits [i*BYTE_SIZE +: BYTE_SIZE]
- addr_a / addr_b  in  ADDR_SIZE  word address
- din_a / din_b  in  DATA_SIZE  write data
- dout_a / dout_b  out  DATA_SIZE  read data
- init_busy  out  1  high while the clear sequencer runs; port requests are ignored
- collision  out  1  one-cycle pulse, aligned with dout, flagging a same-address conflict

## Operation
- Reset values: dout_a=0, dout_b=0, collision=0, init_busy=1, FSM=CLEAR, clear pointer=0.
- FSM CLEAR: each cycle writes 0 to mem[ptr] and increments ptr.
  - After the write at ptr==RAM_SIZE-1, the FSM goes to READY and init_busy falls on that edge.
  - The clear takes exactly RAM_SIZE cycles after rst deasserts.
- FSM READY: ports operate normally. READY is left only by rst.
- rst asserted mid-clear restarts the clear from ptr=0. Memory contents are undefined until the clear completes.
- While in CLEAR: en/we are ignored, dout_a and dout_b stay 0, collision stays 0.
- Port access (READY, en=1):
  - Every enabled lane in we is written.
  - A read always occurs, subject to the RDW mode.
  - en=0 means no write, dout holds, no collision contribution.
- Read-during-write on the same port (any we bit set):
  - Mode 0: dout = post-write word (written lanes new, other lanes old).
  - Mode 1: dout = pre-write word.
  - Mode 2: dout holds its previous value.
  - we all zero is a plain read in every mode.
- Out of range (addr ≥ RAM_SIZE): write dropped, dout = 0, no collision.
- Collision: en_a & en_b & addr_a==addr_b (in range) & (|we_a | |we_b).
  - Per lane, if both ports write the lane, port A's data is stored.
  - Lanes written by only one port take that port's data.
  - A port reading the other port's write target sees pre-write contents for lanes the other port writes; the same-port RDW rule applies to its own lanes.
  - collision is high for exactly the cycle its dout is valid.
- Two reads of the same address are not a collision.

## Timing
- Read latency: 1 cycle. Address sampled at edge N, dout valid after edge N, stable until the next enabled access.
- Write latency: 1 cycle. Data is visible to a read by either port issued at edge N+1.
- collision uses the same pipeline depth as dout.
- init_busy is combinationally derived from FSM state (registered state, no input path).

## Configuration
- TRUE_DPR_OUTREG_EN defined:
  - Adds one output register stage on dout_a, dout_b and collision; read latency becomes 2.
  - The stage is reset to 0 and is advanced only by the corresponding port's enable history.
  - collision is delayed to stay aligned with dout.
- Undefined: latency 1 as above.

## Test plan
- Clear: RAM_SIZE=16, release rst → init_busy high for 16 cycles. Afterwards, reading all 16 addresses on both ports returns 0x00. A write issued during CLEAR has no effect.
- Byte lanes: DATA_SIZE=16, write 0xA1B2 to addr 0x05 with we=2'b11, then 0x7700 with we=2'b10 → read returns 0x77B2.
- RDW modes: mem[3]=0x11, write 0x22 to addr 3 on port A → dout_a=0x22 (mode 0), 0x11 (mode 1), previous dout (mode 2).
- Collision write/write: A writes 0x16 and B writes 0x13 to addr 0x10 with full we → mem[0x10]=0x16, one-cycle collision pulse.
- Collision read/write: mem[0x11]=0x55, A writes 0xA1 while B reads 0x11 → dout_b=0x55, collision=1; next B read returns 0xA1.
- Reset mid-clear: assert rst at clear cycle 7 for 1 cycle → outputs return to 0, and init_busy stays high for a full RAM_SIZE cycles after release.
